// File: rtl/mem_debug_arbiter.sv
// ============================================================================
// mem_debug_arbiter
//
// Purpose:
//   Shares the data-RAM port between the CPU MEM stage and a debug dump engine.
//   In IDLE the CPU owns the RAM port through a combinational pass-through mux.
//   A one-cycle dump request freezes the pipeline. The engine then waits for a
//   halt confirmation and streams DUMP_WORDS 32-bit words, one valid/ready beat
//   per word, before it returns the port to the CPU.
//
// Optional feature (compile-time macro MEM_ARB_WRITE_GUARD_EN):
//   While the CPU owns the port, a CPU write at or above the dumped window
//   (address >= DUMP_WORDS*4) is dropped and o_wr_fault pulses for one cycle.
//   Without the macro every CPU write passes and o_wr_fault stays 0.
//
// Ports:
//   i_clk, i_reset         clock (rising edge), asynchronous active-low reset
//   i_cpu_*                MEM-stage address / store data / re / we / bhw
//   i_mem_rdata            registered read data (one-cycle latency)
//   o_mem_*                address / store data / re / we / bhw to the RAM
//   o_stall_cpu            pipeline freeze while a dump owns the port
//   i_dbg_dump_req         one-cycle dump start request
//   i_dbg_halted           pipeline confirmed halted
//   o_dbg_data/o_dbg_addr  dumped word and its byte address
//   o_dbg_valid/i_dbg_ready  beat handshake
//   o_dbg_busy             dump in progress
//   o_dbg_done             one-cycle dump-complete pulse
//   o_wr_fault             one-cycle blocked-write pulse
// ============================================================================
module mem_debug_arbiter #(
    parameter int NB_WIDTH   = 32,
    parameter int NB_ADDR    = 9,
    parameter int DUMP_WORDS = 128
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_WIDTH-1:0] i_cpu_addr,
    input  logic [NB_WIDTH-1:0] i_cpu_wdata,
    input  logic                i_cpu_re,
    input  logic                i_cpu_we,
    input  logic [2:0]          i_cpu_bhw,
    input  logic [NB_WIDTH-1:0] i_mem_rdata,
    output logic [NB_WIDTH-1:0] o_mem_addr,
    output logic [NB_WIDTH-1:0] o_mem_wdata,
    output logic                o_mem_re,
    output logic                o_mem_we,
    output logic [2:0]          o_mem_bhw,
    output logic                o_stall_cpu,
    input  logic                i_dbg_dump_req,
    input  logic                i_dbg_halted,
    output logic [NB_WIDTH-1:0] o_dbg_data,
    output logic [NB_ADDR-1:0]  o_dbg_addr,
    output logic                o_dbg_valid,
    input  logic                i_dbg_ready,
    output logic                o_dbg_busy,
    output logic                o_dbg_done,
    output logic                o_wr_fault
);

    // A single-word dump still needs a one-bit index register.
    localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DUMP_WORDS - 1);
    localparam logic [2:0]       BHW_WORD = 3'b011;

    // The dumped window has to fit in the RAM byte-address space, and the CPU
    // address must be wide enough to carry a word-aligned dump address.
    generate
        if ((DUMP_WORDS * 4) > (2 ** NB_ADDR)) begin : g_window_check
            $error("mem_debug_arbiter: DUMP_WORDS*4 exceeds 2**NB_ADDR");
        end
        if (NB_WIDTH < (IDX_W + 2)) begin : g_width_check
            $error("mem_debug_arbiter: NB_WIDTH too narrow for dump addresses");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HALT = 3'd1,
        ADDR      = 3'd2,
        CAPT      = 3'd3,
        HOLD      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_nx_s;
    logic                  capture_s;
    logic                  wr_block_s;
    logic [NB_WIDTH-1:0]   dump_mem_addr_s;
    logic [NB_ADDR-1:0]    dump_dbg_addr_s;
    logic [NB_WIDTH-1:0]   dbg_data_r;
    logic [NB_ADDR-1:0]    dbg_addr_r;
    logic                  dbg_valid_r;
    logic                  dbg_busy_r;
    logic                  dbg_done_r;
    logic                  stall_r;
    logic                  wr_fault_r;

    // Byte address of the current word: index*4, zero-extended.
    assign dump_mem_addr_s = NB_WIDTH'({idx_r, 2'b00});
    assign dump_dbg_addr_s = NB_ADDR'({idx_r, 2'b00});

`ifdef MEM_ARB_WRITE_GUARD_EN
    localparam logic [NB_WIDTH-1:0] GUARD_LIMIT = NB_WIDTH'(DUMP_WORDS * 4);
    assign wr_block_s = (state_r == IDLE) && i_cpu_we && (i_cpu_addr >= GUARD_LIMIT);
`else
    assign wr_block_s = 1'b0;
`endif

    // Next-state and index update for the dump sequencer.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_dbg_dump_req) begin
                    state_nx_s = WAIT_HALT;
                    idx_nx_s   = IDX_ZERO;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT_HALT: begin
                if (i_dbg_halted) begin
                    state_nx_s = ADDR;
                end else begin
                    state_nx_s = WAIT_HALT;
                end
            end
            // Losing the halt before the word is captured re-issues the same
            // word after resume; the index is left untouched.
            ADDR: begin
                if (i_dbg_halted) begin
                    state_nx_s = CAPT;
                end else begin
                    state_nx_s = WAIT_HALT;
                end
            end
            CAPT: begin
                if (i_dbg_halted) begin
                    state_nx_s = HOLD;
                    capture_s  = 1'b1;
                end else begin
                    state_nx_s = WAIT_HALT;
                end
            end
            // The beat is already latched, so a halt drop here is ignored and
            // the handshake completes.
            HOLD: begin
                if (i_dbg_ready) begin
                    if (idx_r == IDX_LAST) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = ADDR;
                        idx_nx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_nx_s = HOLD;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
                idx_nx_s   = IDX_ZERO;
            end
            default: begin
                state_nx_s = IDLE;
                idx_nx_s   = IDX_ZERO;
            end
        endcase
    end

    // RAM port mux: CPU pass-through in IDLE, dump reads otherwise.
    always_comb begin
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_mem_re    = i_cpu_re;
        o_mem_we    = i_cpu_we;
        o_mem_bhw   = i_cpu_bhw;
        if (state_r == IDLE) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
            o_mem_re    = i_cpu_re;
            o_mem_we    = i_cpu_we & ~wr_block_s;
            o_mem_bhw   = i_cpu_bhw;
        end else begin
            o_mem_addr  = dump_mem_addr_s;
            o_mem_wdata = {NB_WIDTH{1'b0}};
            o_mem_re    = (state_r == ADDR) || (state_r == CAPT);
            o_mem_we    = 1'b0;
            o_mem_bhw   = BHW_WORD;
        end
    end

    // Sequencer state and word index.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Captured beat; the RAM returns data one cycle after the ADDR cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dbg_data_r <= {NB_WIDTH{1'b0}};
            dbg_addr_r <= {NB_ADDR{1'b0}};
        end else if (capture_s) begin
            dbg_data_r <= i_mem_rdata;
            dbg_addr_r <= dump_dbg_addr_s;
        end else begin
            dbg_data_r <= dbg_data_r;
            dbg_addr_r <= dbg_addr_r;
        end
    end

    // Status flags are registered from the next state so that they line up
    // exactly with the state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dbg_valid_r <= 1'b0;
            dbg_busy_r  <= 1'b0;
            dbg_done_r  <= 1'b0;
            stall_r     <= 1'b0;
            wr_fault_r  <= 1'b0;
        end else begin
            dbg_valid_r <= (state_nx_s == HOLD);
            dbg_busy_r  <= (state_nx_s != IDLE);
            dbg_done_r  <= (state_nx_s == DONE);
            stall_r     <= (state_nx_s != IDLE);
            wr_fault_r  <= wr_block_s;
        end
    end

    assign o_dbg_data  = dbg_data_r;
    assign o_dbg_addr  = dbg_addr_r;
    assign o_dbg_valid = dbg_valid_r;
    assign o_dbg_busy  = dbg_busy_r;
    assign o_dbg_done  = dbg_done_r;
    assign o_stall_cpu = stall_r;
    assign o_wr_fault  = wr_fault_r;

endmodule

// File: tb/tb_mem_debug_arbiter.sv
// ============================================================================
// tb_mem_debug_arbiter
//
// Drives the arbiter with random CPU traffic and random dump handshakes. A
// word-addressed RAM sits behind the DUT's memory port. The reference model is
// a shadow array of the words the CPU legitimately stored. Every completed dump
// must deliver exactly those words, in address order, once each.
// ============================================================================
module tb_mem_debug_arbiter;

    localparam int NBW = 32;
    localparam int NBA = 9;
    localparam int DW  = 4;

`ifdef MEM_ARB_WRITE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            i_clk;
    logic            i_reset;
    logic [NBW-1:0]  i_cpu_addr;
    logic [NBW-1:0]  i_cpu_wdata;
    logic            i_cpu_re;
    logic            i_cpu_we;
    logic [2:0]      i_cpu_bhw;
    logic [NBW-1:0]  i_mem_rdata;
    logic [NBW-1:0]  o_mem_addr;
    logic [NBW-1:0]  o_mem_wdata;
    logic            o_mem_re;
    logic            o_mem_we;
    logic [2:0]      o_mem_bhw;
    logic            o_stall_cpu;
    logic            i_dbg_dump_req;
    logic            i_dbg_halted;
    logic [NBW-1:0]  o_dbg_data;
    logic [NBA-1:0]  o_dbg_addr;
    logic            o_dbg_valid;
    logic            i_dbg_ready;
    logic            o_dbg_busy;
    logic            o_dbg_done;
    logic            o_wr_fault;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] exp_mem [0:DW-1];
    bit          exp_fault = 1'b0;
    logic [31:0] ram [0:63];

    mem_debug_arbiter #(
        .NB_WIDTH   (NBW),
        .NB_ADDR    (NBA),
        .DUMP_WORDS (DW)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_wdata    (i_cpu_wdata),
        .i_cpu_re       (i_cpu_re),
        .i_cpu_we       (i_cpu_we),
        .i_cpu_bhw      (i_cpu_bhw),
        .i_mem_rdata    (i_mem_rdata),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_re       (o_mem_re),
        .o_mem_we       (o_mem_we),
        .o_mem_bhw      (o_mem_bhw),
        .o_stall_cpu    (o_stall_cpu),
        .i_dbg_dump_req (i_dbg_dump_req),
        .i_dbg_halted   (i_dbg_halted),
        .o_dbg_data     (o_dbg_data),
        .o_dbg_addr     (o_dbg_addr),
        .o_dbg_valid    (o_dbg_valid),
        .i_dbg_ready    (i_dbg_ready),
        .o_dbg_busy     (o_dbg_busy),
        .o_dbg_done     (o_dbg_done),
        .o_wr_fault     (o_wr_fault)
    );

    // Clock: 10 time-unit period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Word RAM behind the memory port: word writes, one-cycle registered read.
    always @(posedge i_clk) begin
        if (o_mem_we && (o_mem_bhw == 3'b011)) begin
            ram[o_mem_addr[7:2]] <= o_mem_wdata;
        end
        if (o_mem_re) begin
            i_mem_rdata <= ram[o_mem_addr[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle in IDLE: checks pass-through and the guard rule, updates the model.
    task automatic cpu_cycle(input bit we, input bit re, input logic [31:0] addr,
                             input logic [31:0] data);
        bit blocked;
        @(negedge i_clk);
        chk("wr_fault", 64'(o_wr_fault), 64'(exp_fault));
        i_cpu_we    = we;
        i_cpu_re    = re;
        i_cpu_addr  = addr;
        i_cpu_wdata = data;
        i_cpu_bhw   = 3'b011;
        #1;
        blocked = GUARD && we && (addr >= 32'(DW * 4));
        chk("stall_idle", 64'(o_stall_cpu), 64'd0);
        chk("mem_addr", 64'(o_mem_addr), 64'(addr));
        chk("mem_wdata", 64'(o_mem_wdata), 64'(data));
        chk("mem_re", 64'(o_mem_re), 64'(re));
        chk("mem_we", 64'(o_mem_we), 64'(we && !blocked));
        chk("mem_bhw", 64'(o_mem_bhw), 64'd3);
        exp_fault = blocked;
        if (we && !blocked && (addr < 32'(DW * 4))) begin
            exp_mem[addr[3:2]] = data;
        end
    endtask

    task automatic cpu_random(input int n);
        for (int i = 0; i < n; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            cpu_cycle(kind == 0, kind == 1, 32'($urandom_range(0, 15)) * 32'd4, $urandom);
        end
    endtask

    // Full dump with random ready / halt behaviour; checks every beat against the model.
    task automatic run_dump(input int unsigned rdy_pct, input int unsigned drop_pct,
                            input bit timing);
        int beats = 0;
        int last_beat = 0;
        bit prev_hold = 1'b0;
        bit finished = 1'b0;
        logic [31:0] prev_data = 32'd0;
        logic [8:0]  prev_addr = 9'd0;
        @(negedge i_clk);
        chk("wr_fault_pre", 64'(o_wr_fault), 64'(exp_fault));
        exp_fault      = 1'b0;
        i_cpu_we       = 1'b0;
        i_cpu_re       = 1'b0;
        i_dbg_dump_req = 1'b1;
        i_dbg_halted   = 1'b1;
        i_dbg_ready    = (rdy_pct >= 100);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge i_clk);
            if (prev_hold) begin
                chk("hold_valid", 64'(o_dbg_valid), 64'd1);
                chk("hold_data", 64'(o_dbg_data), 64'(prev_data));
                chk("hold_addr", 64'(o_dbg_addr), 64'(prev_addr));
            end
            if (o_dbg_done) begin
                chk("done_beats", 64'(beats), 64'(DW));
                if (timing) chk("done_latency", 64'(cyc - last_beat), 64'd1);
                i_cpu_we       = 1'b0;
                i_dbg_dump_req = 1'b0;
                i_dbg_ready    = 1'b0;
                @(negedge i_clk);
                chk("done_pulse", 64'(o_dbg_done), 64'd0);
                chk("busy_end", 64'(o_dbg_busy), 64'd0);
                chk("stall_end", 64'(o_stall_cpu), 64'd0);
                chk("valid_end", 64'(o_dbg_valid), 64'd0);
                finished = 1'b1;
            end else begin
                chk("busy", 64'(o_dbg_busy), 64'd1);
                chk("stall", 64'(o_stall_cpu), 64'd1);
                i_dbg_dump_req = ($urandom_range(0, 7) == 0);
                i_dbg_halted   = ($urandom_range(0, 99) >= drop_pct);
                i_dbg_ready    = ($urandom_range(0, 99) < rdy_pct);
                i_cpu_we       = 1'b1;
                i_cpu_addr     = 32'h4;
                i_cpu_wdata    = $urandom;
                #1;
                chk("mem_we_blocked", 64'(o_mem_we), 64'd0);
                if (o_dbg_valid && i_dbg_ready) begin
                    if (beats < DW) begin
                        chk("beat_addr", 64'(o_dbg_addr), 64'(beats * 4));
                        chk("beat_data", 64'(o_dbg_data), 64'(exp_mem[beats]));
                    end else begin
                        chk("extra_beat", 64'(beats), 64'(DW - 1));
                    end
                    if (timing && beats > 0) chk("beat_spacing", 64'(cyc - last_beat), 64'd3);
                    last_beat = cyc;
                    beats++;
                end
                prev_hold = o_dbg_valid && !i_dbg_ready;
                prev_data = o_dbg_data;
                prev_addr = o_dbg_addr;
            end
        end
        if (!finished) chk("dump_timeout", 64'd0, 64'd1);
        i_cpu_we       = 1'b0;
        i_dbg_dump_req = 1'b0;
    endtask

    // Dump interrupted by reset while word 1 waits in HOLD.
    task automatic abort_dump();
        bit got = 1'b0;
        @(negedge i_clk);
        i_cpu_we       = 1'b0;
        i_cpu_re       = 1'b0;
        i_dbg_dump_req = 1'b1;
        i_dbg_halted   = 1'b1;
        i_dbg_ready    = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge i_clk);
            i_dbg_dump_req = 1'b0;
            if (o_dbg_valid && (o_dbg_addr == 9'd4)) begin
                got = 1'b1;
            end else begin
                i_dbg_ready = o_dbg_valid && (o_dbg_addr == 9'd0);
            end
        end
        chk("abort_reached_word1", 64'(got), 64'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("abort_valid", 64'(o_dbg_valid), 64'd0);
        chk("abort_busy", 64'(o_dbg_busy), 64'd0);
        chk("abort_done", 64'(o_dbg_done), 64'd0);
        chk("abort_stall", 64'(o_stall_cpu), 64'd0);
        chk("abort_data", 64'(o_dbg_data), 64'd0);
        chk("abort_addr", 64'(o_dbg_addr), 64'd0);
        chk("abort_fault", 64'(o_wr_fault), 64'd0);
        i_dbg_ready = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("abort_no_done", 64'(o_dbg_done), 64'd0);
        chk("abort_idle", 64'(o_dbg_busy), 64'd0);
        exp_fault = 1'b0;
    endtask

    initial begin
        i_reset        = 1'b0;
        i_cpu_addr     = 32'd0;
        i_cpu_wdata    = 32'd0;
        i_cpu_re       = 1'b0;
        i_cpu_we       = 1'b0;
        i_cpu_bhw      = 3'b011;
        i_dbg_dump_req = 1'b0;
        i_dbg_halted   = 1'b0;
        i_dbg_ready    = 1'b0;
        for (int i = 0; i < DW; i++) exp_mem[i] = 32'd0;

        #23;
        chk("rst_valid", 64'(o_dbg_valid), 64'd0);
        chk("rst_busy", 64'(o_dbg_busy), 64'd0);
        chk("rst_done", 64'(o_dbg_done), 64'd0);
        chk("rst_stall", 64'(o_stall_cpu), 64'd0);
        chk("rst_fault", 64'(o_wr_fault), 64'd0);
        chk("rst_data", 64'(o_dbg_data), 64'd0);
        chk("rst_addr", 64'(o_dbg_addr), 64'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // Fill the dumped window, then the directed store and the guard case.
        for (int w = 0; w < DW; w++) cpu_cycle(1'b1, 1'b0, 32'(w * 4), $urandom);
        cpu_cycle(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        cpu_cycle(1'b1, 1'b0, 32'h20, $urandom);
        cpu_cycle(1'b0, 1'b0, 32'h0, 32'h0);
        cpu_cycle(1'b0, 1'b0, 32'h0, 32'h0);

        run_dump(100, 0, 1'b1);
        cpu_random(40);
        run_dump(40, 0, 1'b0);
        run_dump(70, 25, 1'b0);
        cpu_random(20);
        run_dump(50, 20, 1'b0);
        abort_dump();
        run_dump(100, 0, 1'b1);
        cpu_random(10);
        run_dump(30, 30, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
